serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 142 ++++++++++++++
 tb/tb_serial_subtractor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, one result bit per clock, LSB first.
// The FSM runs IDLE -> SHIFT (WIDTH cycles) -> DONE -> IDLE. Results are registered and
// hold until the next completion. A start seen while busy is dropped, not queued.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int                CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
`ifdef SERIAL_SUB_OVF_EN
  // The operand shift registers lose their MSBs, so the sign bits are kept separately.
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
  logic             w_ovf;
`endif

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell working on the current LSBs and the running borrow.
  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

  // New difference bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    w_res_next            = r_res >> 1;
    w_res_next[WIDTH-1]   = w_d;
  end

`ifdef SERIAL_SUB_OVF_EN
  // Signed overflow: operands of different sign and result sign differs from the minuend.
  assign w_ovf = (r_a_msb ^ r_b_msb) & (r_a_msb ^ r_res[WIDTH-1]);
`endif

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
`endif
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_br  <= w_br_next;
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_diff   <= r_res;
          r_borrow <= r_br;
`ifdef SERIAL_SUB_OVF_EN
          r_ovf    <= w_ovf;
`endif
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8: vector table plus hand-written
// sequences for busy-start rejection, back-to-back starts and mid-operation reset.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .borrow  (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_diff;
    logic         exp_borrow;
    logic         exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One start pulse from IDLE; checks latency, results and single-cycle done.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input string tag);
    int k;
    start = 1'b1;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    k = 0;
    while (k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (done) break;
    end
    chk({tag, "_latency"}, 32'(k), 32'(W + 1));
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("[TB] note: unexpected X in ovf expectation");
`endif
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold_diff"}, 32'(diff), 32'(ed));
  endtask

  vec_t vecs[8];

  initial begin
    int ndone;
    int pos[$];

    vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};

    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    reset_n = 1'b1;

    // First start goes in on the first edge after reset release.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow,
             vecs[i].exp_ovf, $sformatf("vec%0d", i));
    end

    // Start during SHIFT is ignored and operand changes do not disturb the operation.
    ndone   = 0;
    start   = 1'b1;
    a       = 8'h50;
    b       = 8'h10;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) start = 1'b0;
      if (cyc == 2) begin
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
      end
      if (cyc == 3) start = 1'b0;
      if (cyc == 5) chk("busy_ign_busy", 32'(busy), 32'd1);
      if (done) begin
        ndone++;
        chk("busy_ign_pos", 32'(cyc), 32'(W + 2));
        chk("busy_ign_diff", 32'(diff), 32'h40);
        chk("busy_ign_borrow", 32'(borrow), 32'd0);
      end
    end
    chk("busy_ign_ndone", 32'(ndone), 32'd1);

    // Start held high: a new operation every WIDTH+2 cycles.
    start = 1'b1;
    a     = 8'h0A;
    b     = 8'h03;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 30) start = 1'b0;
      if (done) begin
        pos.push_back(cyc);
        chk($sformatf("b2b_diff%0d", pos.size()), 32'(diff), 32'h07);
      end
    end
    chk("b2b_count", 32'(pos.size()), 32'd3);
    for (int i = 0; i < pos.size(); i++) begin
      chk($sformatf("b2b_pos%0d", i), 32'(pos[i]), 32'((i + 1) * (W + 2)));
    end

    // Reset mid-SHIFT aborts the operation with no done afterwards.
    start = 1'b1;
    a     = 8'h35;
    b     = 8'h12;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_borrow", 32'(borrow), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ndone = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
